// File: rtl/phasor_analyzer.sv
// Harmonic analyzer: correlates 256 consecutive valid samples against sine/cosine of one
// harmonic and reports the raw correlation sums plus rounded, saturated 4-bit magnitudes
// in the same format the phasor generator consumes.
module phasor_analyzer #(
  parameter int unsigned NLog2 = 8,
  parameter int unsigned Shift = 37
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [3:0]         freq_i,
  input  logic signed [19:0] sample_in_i,
  input  logic               sample_valid_i,
  output logic               busy_o,
  output logic               result_valid_o,
  output logic signed [43:0] sine_acc_o,
  output logic signed [43:0] cosine_acc_o,
  output logic signed [3:0]  sine_mag_o,
  output logic signed [3:0]  cosine_mag_o
);

  localparam int unsigned NumSamples = 2 ** NLog2;
  localparam logic [NLog2:0] LastCount = (NLog2 + 1)'(NumSamples - 1);

  // First quadrant of round(32767 * sin(2*pi*k/256)), k = 0..64; the rest follows by symmetry,
  // which also makes every full-period sum cancel exactly.
  localparam int QuarterSine [65] = '{
        0,   804,  1608,  2410,  3212,  4011,  4808,  5602,
     6393,  7179,  7962,  8739,  9512, 10278, 11039, 11793,
    12539, 13279, 14010, 14732, 15446, 16151, 16846, 17530,
    18204, 18868, 19519, 20159, 20787, 21403, 22005, 22594,
    23170, 23731, 24279, 24811, 25329, 25832, 26319, 26790,
    27245, 27683, 28105, 28510, 28898, 29268, 29621, 29956,
    30273, 30571, 30852, 31113, 31356, 31580, 31785, 31971,
    32137, 32285, 32412, 32521, 32609, 32678, 32728, 32757,
    32767
  };

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  function automatic logic signed [15:0] rom_read(input logic [7:0] addr);
    logic [6:0]         idx;
    logic signed [15:0] mag;
    idx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
    mag = 16'(QuarterSine[idx]);
    return addr[7] ? -mag : mag;
  endfunction

  // Round half up, arithmetic shift, then clamp into the signed 4-bit range.
  function automatic logic signed [3:0] to_mag(input logic signed [43:0] acc,
                                               input int unsigned sh);
    logic signed [44:0] sum;
    logic signed [44:0] q;
    sum = 45'(acc) + (45'sd1 <<< (sh - 1));
    q   = sum >>> sh;
    if (q > 45'sd7) begin
      return 4'sd7;
    end else if (q < -45'sd8) begin
      return -4'sd8;
    end
    return q[3:0];
  endfunction

  state_e             state_q, state_d;
  logic [NLog2-1:0]   phase_q, phase_d;
  logic [NLog2:0]     count_q, count_d;
  logic [3:0]         freq_q, freq_d;
  logic [1:0]         drain_q, drain_d;
  logic               accept, clear, post;

  logic [7:0]         addr_q;
  logic signed [19:0] sample_d1_q, sample_s1_q;
  logic               valid_d1_q, valid_s1_q, valid_d2_q;
  logic signed [15:0] sin_s1_q, cos_s1_q;
  logic signed [35:0] prod_sin_q, prod_cos_q;
  logic signed [43:0] acc_sin_q, acc_cos_q;

  logic signed [43:0] sine_acc_q, cosine_acc_q;
  logic signed [3:0]  sine_mag_q, cosine_mag_q;

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      phase_q <= '0;
      count_q <= '0;
      freq_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
      freq_q  <= freq_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic: sample acceptance, phase stepping and drain sequencing.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    freq_d  = freq_q;
    drain_d = drain_q;
    accept  = 1'b0;
    clear   = 1'b0;
    post    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRun;
          freq_d  = freq_i;
          phase_d = '0;
          count_d = '0;
          clear   = 1'b1;
        end
      end
      StRun: begin
        if (sample_valid_i) begin
          accept  = 1'b1;
          phase_d = phase_q + NLog2'(freq_q);
          count_d = count_q + 1'b1;
          if (count_q == LastCount) begin
            state_d = StDrain;
            drain_d = '0;
          end
        end
      end
      StDrain: begin
        // Last sample needs ROM, product and accumulate stages before the sums are final.
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd3) begin
          state_d = StDone;
          post    = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Correlation pipeline: sample capture, ROM read, multiply, accumulate.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      sample_d1_q <= '0;
      valid_d1_q  <= 1'b0;
      sample_s1_q <= '0;
      sin_s1_q    <= '0;
      cos_s1_q    <= '0;
      valid_s1_q  <= 1'b0;
      prod_sin_q  <= '0;
      prod_cos_q  <= '0;
      valid_d2_q  <= 1'b0;
      acc_sin_q   <= '0;
      acc_cos_q   <= '0;
    end else if (clear) begin
      valid_d1_q <= 1'b0;
      valid_s1_q <= 1'b0;
      valid_d2_q <= 1'b0;
      acc_sin_q  <= '0;
      acc_cos_q  <= '0;
    end else begin
      valid_d1_q <= accept;
      if (accept) begin
        addr_q      <= 8'(phase_q);
        sample_d1_q <= sample_in_i;
      end
      valid_s1_q  <= valid_d1_q;
      sample_s1_q <= sample_d1_q;
      sin_s1_q    <= rom_read(addr_q);
      cos_s1_q    <= rom_read(addr_q + 8'd64);
      valid_d2_q  <= valid_s1_q;
      prod_sin_q  <= 36'(sample_s1_q) * 36'(sin_s1_q);
      prod_cos_q  <= 36'(sample_s1_q) * 36'(cos_s1_q);
      if (valid_d2_q) begin
        acc_sin_q <= acc_sin_q + 44'(prod_sin_q);
        acc_cos_q <= acc_cos_q + 44'(prod_cos_q);
      end
    end
  end

  // Result registers hold until the next measurement completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sine_acc_q   <= '0;
      cosine_acc_q <= '0;
      sine_mag_q   <= '0;
      cosine_mag_q <= '0;
    end else if (post) begin
      sine_acc_q   <= acc_sin_q;
      cosine_acc_q <= acc_cos_q;
      // DC correlates against 256*A^2 rather than 128*A^2, hence one extra shift.
      sine_mag_q   <= (freq_q == 4'd0) ? 4'sd0 : to_mag(acc_sin_q, Shift);
      cosine_mag_q <= to_mag(acc_cos_q, (freq_q == 4'd0) ? Shift + 1 : Shift);
    end
  end

  assign busy_o         = (state_q == StRun) || (state_q == StDrain);
  assign result_valid_o = (state_q == StDone);
  assign sine_acc_o     = sine_acc_q;
  assign cosine_acc_o   = cosine_acc_q;
  assign sine_mag_o     = sine_mag_q;
  assign cosine_mag_o   = cosine_mag_q;

endmodule

// File: tb/tb_phasor_analyzer.sv
// Directed bench for phasor_analyzer: loop-back phasor stimulus built from an independent
// sine table, with expected sums from a small correlation model and hand-derived magnitudes.
module tb_phasor_analyzer;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic [3:0]         freq = 4'd0;
  logic signed [19:0] sample_in = '0;
  logic               sample_valid = 1'b0;
  logic               busy, result_valid;
  logic signed [43:0] sine_acc, cosine_acc;
  logic signed [3:0]  sine_mag, cosine_mag;

  int checks = 0;
  int errors = 0;
  int sin_tab [256];

  phasor_analyzer dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .freq_i         (freq),
    .sample_in_i    (sample_in),
    .sample_valid_i (sample_valid),
    .busy_o         (busy),
    .result_valid_o (result_valid),
    .sine_acc_o     (sine_acc),
    .cosine_acc_o   (cosine_acc),
    .sine_mag_o     (sine_mag),
    .cosine_mag_o   (cosine_mag)
  );

  always #5 clk = ~clk;

  function automatic int stim(input int f, input int s, input int c, input int dc, input int n);
    int ph;
    ph = (n * f) % 256;
    return dc + s * sin_tab[ph] + c * sin_tab[(ph + 64) % 256];
  endfunction

  function automatic longint model_acc(input int f, input int s, input int c, input int dc,
                                       input bit cosine);
    longint acc;
    int ph;
    acc = 0;
    for (int n = 0; n < 256; n++) begin
      ph = (n * f) % 256;
      acc += longint'(stim(f, s, c, dc, n)) *
             longint'(cosine ? sin_tab[(ph + 64) % 256] : sin_tab[ph]);
    end
    return acc;
  endfunction

  // One full measurement; returns at the negedge where result_valid was seen (or on timeout).
  task automatic measure(input int f, input int s, input int c, input int dc, input bit gaps,
                         input bit mid_start, output int edges, output bit busy_seen,
                         output logic signed [43:0] sa, output logic signed [43:0] ca,
                         output logic signed [3:0] sm, output logic signed [3:0] cm);
    int n;
    int i;
    @(posedge clk); #1;
    start = 1'b1;
    freq  = 4'(f);
    @(posedge clk); #1;
    start = 1'b0;
    busy_seen = busy;
    n = 0;
    while (n < 256) begin
      sample_valid = !gaps || ($urandom_range(0, 1) == 1);
      sample_in = sample_valid ? 20'(stim(f, s, c, dc, n)) : 20'($urandom);
      if (mid_start && n == 50) begin
        start = 1'b1;
        freq  = 4'd15;
      end else begin
        start = 1'b0;
        freq  = 4'(f);
      end
      @(posedge clk); #1;
      if (sample_valid) n++;
    end
    sample_valid = 1'b0;
    start = 1'b0;
    freq = 4'(f);
    i = 0;
    while (i < 20 && !result_valid) begin
      @(negedge clk);
      i++;
    end
    edges = result_valid ? i - 1 : -1;
    sa = sine_acc;
    ca = cosine_acc;
    sm = sine_mag;
    cm = cosine_mag;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL rst_result_valid: got %b expected 0", result_valid);
    end
    checks++;
    if (sine_acc !== 44'sd0) begin errors++; $display("FAIL rst_sine_acc: got %0d expected 0", sine_acc); end
    checks++;
    if (cosine_acc !== 44'sd0) begin
      errors++; $display("FAIL rst_cosine_acc: got %0d expected 0", cosine_acc);
    end
    checks++;
    if (sine_mag !== 4'sd0) begin errors++; $display("FAIL rst_sine_mag: got %0d expected 0", sine_mag); end
    checks++;
    if (cosine_mag !== 4'sd0) begin
      errors++; $display("FAIL rst_cosine_mag: got %0d expected 0", cosine_mag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_loopback_f1();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    longint es, ec;
    es = model_acc(1, 1, 1, 0, 1'b0);
    ec = model_acc(1, 1, 1, 0, 1'b1);
    measure(1, 1, 1, 0, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (edges !== 4) begin errors++; $display("FAIL f1_latency: got %0d expected 4", edges); end
    checks++;
    if (bs !== 1'b1) begin errors++; $display("FAIL f1_busy_after_start: got %b expected 1", bs); end
    checks++;
    if (sm !== 4'sd1) begin errors++; $display("FAIL f1_sine_mag: got %0d expected 1", sm); end
    checks++;
    if (cm !== 4'sd1) begin errors++; $display("FAIL f1_cosine_mag: got %0d expected 1", cm); end
    checks++;
    if (sa !== 44'(es)) begin errors++; $display("FAIL f1_sine_acc: got %0d expected %0d", sa, es); end
    checks++;
    if (ca !== 44'(ec)) begin errors++; $display("FAIL f1_cosine_acc: got %0d expected %0d", ca, ec); end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0) begin
      errors++; $display("FAIL f1_pulse_width: got %b expected 0", result_valid);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL f1_busy_done: got %b expected 0", busy); end
  endtask

  task automatic test_loopback_f5();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    int s_v [2] = '{3, -8};
    int c_v [2] = '{-3, 7};
    longint es, ec;
    for (int k = 0; k < 2; k++) begin
      es = model_acc(5, s_v[k], c_v[k], 0, 1'b0);
      ec = model_acc(5, s_v[k], c_v[k], 0, 1'b1);
      measure(5, s_v[k], c_v[k], 0, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
      checks++;
      if (edges !== 4) begin errors++; $display("FAIL f5_latency[%0d]: got %0d expected 4", k, edges); end
      checks++;
      if (sm !== 4'(s_v[k])) begin
        errors++; $display("FAIL f5_sine_mag[%0d]: got %0d expected %0d", k, sm, s_v[k]);
      end
      checks++;
      if (cm !== 4'(c_v[k])) begin
        errors++; $display("FAIL f5_cosine_mag[%0d]: got %0d expected %0d", k, cm, c_v[k]);
      end
      checks++;
      if (sa !== 44'(es)) begin
        errors++; $display("FAIL f5_sine_acc[%0d]: got %0d expected %0d", k, sa, es);
      end
      checks++;
      if (ca !== 44'(ec)) begin
        errors++; $display("FAIL f5_cosine_acc[%0d]: got %0d expected %0d", k, ca, ec);
      end
    end
  endtask

  task automatic test_gaps();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    longint es, ec;
    es = model_acc(5, 3, -3, 0, 1'b0);
    ec = model_acc(5, 3, -3, 0, 1'b1);
    measure(5, 3, -3, 0, 1'b1, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (edges !== 4) begin errors++; $display("FAIL gaps_latency: got %0d expected 4", edges); end
    checks++;
    if (sa !== 44'(es)) begin errors++; $display("FAIL gaps_sine_acc: got %0d expected %0d", sa, es); end
    checks++;
    if (ca !== 44'(ec)) begin errors++; $display("FAIL gaps_cosine_acc: got %0d expected %0d", ca, ec); end
  endtask

  task automatic test_dc();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    longint ec;
    // freq 0: cosine sum is 256 * 131068 * 32767, sine table at phase 0 is zero.
    ec = 64'sd256 * 64'sd131068 * 64'sd32767;
    measure(0, 0, 0, 131068, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (sm !== 4'sd0) begin errors++; $display("FAIL dc0_sine_mag: got %0d expected 0", sm); end
    checks++;
    if (cm !== 4'sd4) begin errors++; $display("FAIL dc0_cosine_mag: got %0d expected 4", cm); end
    checks++;
    if (sa !== 44'sd0) begin errors++; $display("FAIL dc0_sine_acc: got %0d expected 0", sa); end
    checks++;
    if (ca !== 44'(ec)) begin errors++; $display("FAIL dc0_cosine_acc: got %0d expected %0d", ca, ec); end
    // freq 3 visits every table entry once, so a constant input cancels exactly.
    measure(3, 0, 0, 131068, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (sm !== 4'sd0) begin errors++; $display("FAIL dc3_sine_mag: got %0d expected 0", sm); end
    checks++;
    if (cm !== 4'sd0) begin errors++; $display("FAIL dc3_cosine_mag: got %0d expected 0", cm); end
    checks++;
    if (sa !== 44'sd0) begin errors++; $display("FAIL dc3_sine_acc: got %0d expected 0", sa); end
    checks++;
    if (ca !== 44'sd0) begin errors++; $display("FAIL dc3_cosine_acc: got %0d expected 0", ca); end
  endtask

  task automatic test_overdrive();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    longint es;
    es = model_acc(1, 14, 0, 0, 1'b0);
    measure(1, 14, 0, 0, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (!(sa > 0)) begin errors++; $display("FAIL od_sine_acc_sign: got %0d expected > 0", sa); end
    checks++;
    if (sa !== 44'(es)) begin errors++; $display("FAIL od_sine_acc: got %0d expected %0d", sa, es); end
    checks++;
    if (sm !== 4'sd7) begin errors++; $display("FAIL od_sine_mag: got %0d expected 7", sm); end
    checks++;
    if (cm !== 4'sd0) begin errors++; $display("FAIL od_cosine_mag: got %0d expected 0", cm); end
  endtask

  task automatic test_start_in_done();
    int edges; bit bs;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    measure(2, -2, 0, 0, 1'b0, 1'b0, edges, bs, sa, ca, sm, cm);
    checks++;
    if (sm !== -4'sd2) begin errors++; $display("FAIL done_sine_mag: got %0d expected -2", sm); end
    checks++;
    if (cm !== 4'sd0) begin errors++; $display("FAIL done_cosine_mag: got %0d expected 0", cm); end
    // Still in the result_valid cycle: this start must be ignored, then taken in IDLE.
    start = 1'b1;
    freq  = 4'd7;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored: got busy %b expected 0", busy); end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL idle_start_taken: got busy %b expected 1", busy); end
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_abort_restart();
    int edges; bit bs; int rv_seen;
    logic signed [43:0] sa, ca; logic signed [3:0] sm, cm;
    longint es, ec;
    @(posedge clk); #1;
    start = 1'b1;
    freq  = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      sample_valid = 1'b1;
      sample_in = 20'(stim(1, 3, 3, 0, n));
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    sample_valid = 1'b0;
    #2;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    checks++;
    if (result_valid !== 1'b0) begin errors++; $display("FAIL abort_rv: got %b expected 0", result_valid); end
    checks++;
    if (sine_acc !== 44'sd0) begin errors++; $display("FAIL abort_sine_acc: got %0d expected 0", sine_acc); end
    checks++;
    if (cosine_acc !== 44'sd0) begin
      errors++; $display("FAIL abort_cosine_acc: got %0d expected 0", cosine_acc);
    end
    checks++;
    if (sine_mag !== 4'sd0) begin errors++; $display("FAIL abort_sine_mag: got %0d expected 0", sine_mag); end
    checks++;
    if (cosine_mag !== 4'sd0) begin
      errors++; $display("FAIL abort_cosine_mag: got %0d expected 0", cosine_mag);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rv_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    checks++;
    if (rv_seen !== 0) begin errors++; $display("FAIL abort_no_result: got %0d pulses expected 0", rv_seen); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy %b expected 0", busy); end
    es = model_acc(1, 2, -5, 0, 1'b0);
    ec = model_acc(1, 2, -5, 0, 1'b1);
    measure(1, 2, -5, 0, 1'b0, 1'b1, edges, bs, sa, ca, sm, cm);
    checks++;
    if (edges !== 4) begin errors++; $display("FAIL restart_latency: got %0d expected 4", edges); end
    checks++;
    if (sm !== 4'sd2) begin errors++; $display("FAIL restart_sine_mag: got %0d expected 2", sm); end
    checks++;
    if (cm !== -4'sd5) begin errors++; $display("FAIL restart_cosine_mag: got %0d expected -5", cm); end
    checks++;
    if (sa !== 44'(es)) begin errors++; $display("FAIL restart_sine_acc: got %0d expected %0d", sa, es); end
    checks++;
    if (ca !== 44'(ec)) begin
      errors++; $display("FAIL restart_cosine_acc: got %0d expected %0d", ca, ec);
    end
  endtask

  initial begin
    real v;
    for (int k = 0; k < 256; k++) begin
      v = 32767.0 * $sin(2.0 * 3.141592653589793 * real'(k) / 256.0);
      sin_tab[k] = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    end
    test_reset();
    test_loopback_f1();
    test_loopback_f5();
    test_gaps();
    test_dc();
    test_overdrive();
    test_start_in_done();
    test_abort_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
